// File: rtl/fir_out_decim.sv
// Decimating, rounding and saturating output stage for the FIR filter.
// Results are buffered in a first-word-fall-through FIFO behind a valid/ready port.
`timescale 1ns/1ps
module fir_out_decim #(
    parameter int IN_BITS    = 37,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_BITS-1:0]            fir_data_in,
    input  logic                          fir_data_vld,
    output logic [OUT_W-1:0]              dout,
    output logic                          dout_vld,
    input  logic                          dout_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   sat_cnt,
    output logic                          overflow,
    input  logic                          clr_stat
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int XW   = IN_BITS + 1;

    localparam logic [XW-1:0] RND   = {{(XW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [XW-1:0] MAX_V = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [XW-1:0] MIN_V = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [PH_W-1:0]   phase;
    logic              accept;

    logic [XW-1:0]     s1_data;
    logic              s1_vld;

    logic signed [XW-1:0] shifted;
    logic              sat_hi;
    logic              sat_lo;
    logic [OUT_W-1:0]  clipped;

    logic [OUT_W-1:0]  s2_data;
    logic              s2_sat;
    logic              s2_vld;

    logic [OUT_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic [OUT_W-1:0]  last_out;
    logic              do_pop;
    logic              do_push;
    logic              drop;

    assign accept = fir_data_vld && (phase == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (fir_data_vld) begin
            if (phase == PH_W'(DECIM - 1))
                phase <= '0;
            else
                phase <= phase + PH_W'(1);
        end
    end

    // The extra MSB keeps the rounding offset from wrapping the largest positive input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data <= '0;
            s1_vld  <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept)
                s1_data <= {fir_data_in[IN_BITS-1], fir_data_in} + RND;
        end
    end

    assign shifted = $signed(s1_data) >>> SHIFT;
    assign sat_hi  = shifted > $signed(MAX_V);
    assign sat_lo  = shifted < $signed(MIN_V);

    always_comb begin
        clipped = shifted[OUT_W-1:0];
        if (sat_hi)
            clipped = {1'b0, {(OUT_W-1){1'b1}}};
        else if (sat_lo)
            clipped = {1'b1, {(OUT_W-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_data <= '0;
            s2_sat  <= 1'b0;
            s2_vld  <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_data <= clipped;
                s2_sat  <= sat_hi || sat_lo;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign dout_vld = (level != '0);
    assign do_pop   = dout_vld && dout_rdy;
    assign do_push  = s2_vld && ((level < LW'(FIFO_DEPTH)) || do_pop);
    assign drop     = s2_vld && !do_push;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= s2_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                level <= level + LW'(1);
            else if (do_pop && !do_push)
                level <= level - LW'(1);
        end
    end

    // Remembers the most recently delivered sample so dout holds while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst)
            last_out <= '0;
        else if (do_pop)
            last_out <= mem[rd_ptr];
    end

    assign dout       = dout_vld ? mem[rd_ptr] : last_out;
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt  <= '0;
            overflow <= 1'b0;
        end else if (clr_stat) begin
            sat_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (s2_vld && s2_sat && (sat_cnt != 16'hFFFF))
                sat_cnt <= sat_cnt + 16'd1;
            if (drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: doc/fir_out_decim.md
Name:
fir_out_decim

Overview:
- Consumer stage that sits directly after the FIR filter's output port (`data_out` / `data_out_vld`).
- Decimates the full-precision FIR result stream by DECIM, then rounds and saturates it to OUT_W bits.
- Buffers results in a small first-word-fall-through (FWFT) FIFO and delivers them downstream over a valid/ready handshake.
- Reports saturation events and FIFO overflow for debug.

Parameters:
- IN_BITS, 37: width of the signed FIR result (DATA_BITS+COEF_BITS+EXTEND_BITS).
- OUT_W, 16: width of the signed output sample.
- SHIFT, 15: LSBs discarded by rounding; range 1..IN_BITS-2.
- DECIM, 4: decimation factor; range 1..256.
- FIFO_DEPTH, 8: FIFO entries; power of 2, at least 2.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset. Synchronous and active-high.
- fir_data_in, in, IN_BITS: signed FIR result.
- fir_data_vld, in, 1: qualifies fir_data_in. One sample per asserted cycle; back-to-back cycles are allowed.
- dout, out, OUT_W: signed output sample at the FIFO head.
- dout_vld, out, 1: FIFO not empty.
- dout_rdy, in, 1: downstream accepts dout.
- fifo_level, out, clog2(FIFO_DEPTH)+1: current number of FIFO entries.
- sat_cnt, out, 16: count of saturated samples. Sticks at 16'hFFFF.
- overflow, out, 1: sticky flag; set when a sample is dropped because the FIFO is full.
- clr_stat, in, 1: clears sat_cnt and overflow.

Behaviour:
- Reset (sampled on the rising clk edge while rst=1):
  - phase counter = 0; FIFO empty; pipeline valids = 0.
  - dout = 0, dout_vld = 0, fifo_level = 0, sat_cnt = 0, overflow = 0.
  - Reset mid-operation discards all FIFO contents and in-flight samples. The first sample after reset is phase 0.
- Decimation:
  - phase increments on every fir_data_vld and wraps from DECIM-1 to 0.
  - A sample is accepted only when phase == 0 at its vld cycle. Other samples are discarded.
  - With DECIM=1, every sample is accepted.
- Stage 1 (registered):
  - Sign-extend the accepted sample to IN_BITS+1 bits, then add 2^(SHIFT-1).
  - The extra bit prevents wrap on the largest positive input.
- Stage 2 (registered):
  - Arithmetic shift right by SHIFT (round half toward +inf).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If clamping occurs, assert the internal sat event.
- Latency:
  - Accepted vld at cycle N → FIFO write at edge N+2.
  - Sample visible on dout / dout_vld at cycle N+3 when the FIFO was empty.
- FIFO:
  - First-word-fall-through: dout always equals the head entry while dout_vld=1.
  - Pop occurs when dout_vld && dout_rdy.
  - Write occurs when stage 2 is valid and (level < FIFO_DEPTH, or a pop happens in the same cycle).
  - Simultaneous push and pop leaves level unchanged.
  - Push when full with no pop: sample dropped, overflow set, level stays at FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
  - dout holds its last value while dout_vld=0.
  - dout_rdy with an empty FIFO has no effect.
- Statistics:
  - sat_cnt increments on each sat event whose sample reaches the FIFO-write stage, including samples that are then dropped.
  - clr_stat has priority: a sat or overflow event in the same cycle as clr_stat is lost, and the result is 0.

Test Plan:
1. Rounding, DECIM=1, SHIFT=15, inputs 114688, -16384, -16385, 49151 → dout 4, 0, -1, 1 in order; each appears 3 cycles after its vld with dout_rdy=1; sat_cnt stays 0.
2. Saturation, inputs 2^31, -2^31, 2^30 → dout 32767, -32768, 32767; sat_cnt=3.
3. Decimation, DECIM=4, 10 back-to-back vld samples with values k·32768 for k=1..10 → dout 1, 5, 9; exactly 3 pops.
4. Overflow, DECIM=1, dout_rdy=0, 10 samples of 1..10·32768 → fifo_level=8, overflow=1 after the 9th sample. Then dout_rdy=1 → dout 1..8; 9 and 10 are lost; clr_stat → overflow=0.
5. Full with simultaneous pop: FIFO full, dout_rdy=1 in the same cycle as a push → push accepted, level stays 8, overflow stays 0.
6. Reset mid-stream: rst pulse with 5 entries buffered and one sample in flight → next cycle dout_vld=0, fifo_level=0, sat_cnt=0. The next vld sample is accepted as phase 0.
